// File: rtl/bubble_hit_manager.sv
// bubble_hit_manager
// Turns per-frame swimmer/bubble contacts into pop requests for the bubble
// movers (level request, held until the mover acks), and keeps the score,
// the oxygen level and the sticky game-over flag for the HUD.
module bubble_hit_manager #(
    parameter int NUM_B       = 7,
    parameter int POINTS      = 5,
    parameter int O2_MAX      = 100,
    parameter int O2_GAIN     = 10,
    parameter int O2_PERIOD   = 30,
    parameter int COOL_FRAMES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [NUM_B-1:0] collisionBS,
    input  logic [NUM_B-1:0] respawn_ack,
    output logic [NUM_B-1:0] pop_req,
    output logic [9:0]       score,
    output logic [6:0]       oxygen,
    output logic             hit_pulse,
    output logic             game_over
);

    localparam int COOL_W = $clog2(COOL_FRAMES + 1);
    localparam int FC_W   = $clog2(O2_PERIOD);
    localparam int HIT_W  = $clog2(NUM_B + 1);
    localparam logic signed [9:0] O2_MAX_S = 10'(O2_MAX);

    typedef enum logic [1:0] {
        ACTIVE,
        POPPED,
        COOLDOWN
    } bubbleState_t;

    bubbleState_t      state     [NUM_B];
    bubbleState_t      stateNext [NUM_B];
    logic [COOL_W-1:0] coolCnt     [NUM_B];
    logic [COOL_W-1:0] coolCntNext [NUM_B];

    logic [NUM_B-1:0]  newHit;
    logic [NUM_B-1:0]  popReqNext;
    logic [HIT_W-1:0]  hitCount;
    logic [FC_W-1:0]   frameCnt;
    logic [FC_W-1:0]   frameCntNext;
    logic              dec;
    logic              tickLive;
    logic [12:0]       scoreSum;
    logic [9:0]        scoreNext;
    logic signed [9:0] oxySum;
    logic [6:0]        oxygenNext;
    logic              gameOverNext;

    // Next-state for every bubble FSM plus the score/oxygen datapath.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        newHit       = '0;
        popReqNext   = '0;
        hitCount     = '0;
        frameCntNext = frameCnt;
        scoreSum     = '0;
        scoreNext    = score;
        oxySum       = '0;
        oxygenNext   = oxygen;
        gameOverNext = game_over;
        tickLive     = frame_tick && !game_over;
        dec          = (frameCnt == FC_W'(O2_PERIOD - 1));

        for (int i = 0; i < NUM_B; i++) begin
            stateNext[i]   = state[i];
            coolCntNext[i] = coolCnt[i];
            case (state[i])
                ACTIVE: begin
                    if (tickLive && collisionBS[i]) begin
                        stateNext[i] = POPPED;
                        newHit[i]    = 1'b1;
                    end
                end
                POPPED: begin
                    if (respawn_ack[i]) begin
                        stateNext[i]   = COOLDOWN;
                        coolCntNext[i] = COOL_W'(COOL_FRAMES);
                    end
                end
                COOLDOWN: begin
                    // A collision on the tick that ends the cooldown is not
                    // seen: the bubble is still in COOLDOWN on that cycle.
                    if (frame_tick) begin
                        if (coolCnt[i] <= COOL_W'(1)) begin
                            coolCntNext[i] = '0;
                            stateNext[i]   = ACTIVE;
                        end else begin
                            coolCntNext[i] = coolCnt[i] - COOL_W'(1);
                        end
                    end
                end
                default: stateNext[i] = ACTIVE;
            endcase
            popReqNext[i] = (stateNext[i] == POPPED);
            hitCount      = hitCount + HIT_W'(newHit[i]);
        end

        if (tickLive) begin
            frameCntNext = dec ? '0 : frameCnt + FC_W'(1);

            scoreSum  = 13'(score) + 13'(hitCount) * 13'(POINTS);
            scoreNext = (scoreSum > 13'd1023) ? 10'd1023 : scoreSum[9:0];

            // Signed so that a decrement from zero cannot wrap before clamping.
            oxySum = $signed(10'(oxygen)) + $signed(10'(hitCount) * 10'(O2_GAIN))
                   - $signed(10'(dec));
            if (oxySum < 10'sd0) begin
                oxygenNext = '0;
            end else if (oxySum > O2_MAX_S) begin
                oxygenNext = 7'(O2_MAX);
            end else begin
                oxygenNext = oxySum[6:0];
            end
            gameOverNext = (oxygenNext == 7'd0);
        end
    end

    // All state and every output is registered here; reset may arrive at any time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the per-bubble arrays are a handful of flops, not a RAM,
            // so resetting them in a loop is intended and cheap.
            for (int i = 0; i < NUM_B; i++) begin
                state[i]   <= ACTIVE;
                coolCnt[i] <= '0;
            end
            pop_req   <= '0;
            score     <= '0;
            oxygen    <= 7'(O2_MAX);
            hit_pulse <= 1'b0;
            game_over <= 1'b0;
            frameCnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            for (int i = 0; i < NUM_B; i++) begin
                state[i]   <= stateNext[i];
                coolCnt[i] <= coolCntNext[i];
            end
            pop_req   <= popReqNext;
            score     <= scoreNext;
            oxygen    <= oxygenNext;
            hit_pulse <= (hitCount != '0);
            game_over <= gameOverNext;
            frameCnt  <= frameCntNext;
        end
    end

endmodule

// File: tb/tb_bubble_hit_manager.sv
// Self-checking bench for bubble_hit_manager: a behavioural model pushes the
// expected outputs for every cycle onto a queue, which is popped and compared
// after the clock edge; scenario tasks add direct checks of key values.
module tb_bubble_hit_manager;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [6:0] collisionBS = '0;
    logic [6:0] respawn_ack = '0;
    logic [6:0] pop_req;
    logic [9:0] score;
    logic [6:0] oxygen;
    logic       hit_pulse;
    logic       game_over;

    bubble_hit_manager dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .collisionBS(collisionBS),
        .respawn_ack(respawn_ack),
        .pop_req    (pop_req),
        .score      (score),
        .oxygen     (oxygen),
        .hit_pulse  (hit_pulse),
        .game_over  (game_over)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] popReq;
        logic [9:0] score;
        logic [6:0] oxygen;
        logic       hitPulse;
        logic       gameOver;
    } outs_t;

    outs_t expQ[$];
    int    checks = 0;
    int    passes = 0;

    // Reference model: 0 = active, 1 = popped, 2 = cooldown.
    int mState[7];
    int mCool[7];
    int mScore;
    int mOxy;
    int mFc;
    bit mGo;

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            mState[i] = 0;
            mCool[i]  = 0;
        end
        mScore = 0;
        mOxy   = 100;
        mFc    = 0;
        mGo    = 1'b0;
        expQ.delete();
    endtask

    // One clock cycle: drive inputs, predict, then compare after the edge.
    task automatic step(input bit tick, input logic [6:0] coll, input logic [6:0] ack);
        outs_t e;
        outs_t got;
        int    n;
        int    dec;
        @(negedge clock);
        frame_tick  = tick;
        collisionBS = coll;
        respawn_ack = ack;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (mState[i] == 0) begin
                if (tick && coll[i] && !mGo) begin
                    mState[i] = 1;
                    n++;
                end
            end else if (mState[i] == 1) begin
                if (ack[i]) begin
                    mState[i] = 2;
                    mCool[i]  = 8;
                end
            end else if (tick) begin
                mCool[i]--;
                if (mCool[i] == 0) mState[i] = 0;
            end
        end
        if (tick && !mGo) begin
            mScore = mScore + n * 5;
            if (mScore > 1023) mScore = 1023;
            dec = (mFc == 29) ? 1 : 0;
            mFc = (mFc == 29) ? 0 : mFc + 1;
            mOxy = mOxy + n * 10 - dec;
            if (mOxy > 100) mOxy = 100;
            if (mOxy < 0) mOxy = 0;
            if (mOxy == 0) mGo = 1'b1;
        end
        for (int i = 0; i < 7; i++) e.popReq[i] = (mState[i] == 1);
        e.score    = mScore[9:0];
        e.oxygen   = mOxy[6:0];
        e.hitPulse = (n > 0);
        e.gameOver = mGo;
        expQ.push_back(e);

        @(posedge clock);
        #1;
        got = {pop_req, score, oxygen, hit_pulse, game_over};
        e = expQ.pop_front();
        checks++;
        if (got !== e)
            $display("FAIL sb t=%0t pop_req %b want %b, score %0d want %0d, oxygen %0d want %0d, hit_pulse %b want %b, game_over %b want %b",
                     $time, got.popReq, e.popReq, got.score, e.score, got.oxygen, e.oxygen,
                     got.hitPulse, e.hitPulse, got.gameOver, e.gameOver);
        else passes++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clock);
        frame_tick  = 1'b0;
        collisionBS = '0;
        respawn_ack = '0;
        #2 reset = 1'b1;
        #1;
        checks++; if (pop_req !== 7'd0) $display("FAIL rst_pop_req got %b want 0", pop_req); else passes++;
        checks++; if (score !== 10'd0) $display("FAIL rst_score got %0d want 0", score); else passes++;
        checks++; if (oxygen !== 7'd100) $display("FAIL rst_oxygen got %0d want 100", oxygen); else passes++;
        checks++; if (hit_pulse !== 1'b0) $display("FAIL rst_hit_pulse got %b want 0", hit_pulse); else passes++;
        checks++; if (game_over !== 1'b0) $display("FAIL rst_game_over got %b want 0", game_over); else passes++;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single_hit();
        step(1'b1, 7'b0000100, 7'd0);
        checks++; if (pop_req !== 7'b0000100) $display("FAIL t1_pop_req got %b want 0000100", pop_req); else passes++;
        checks++; if (score !== 10'd5) $display("FAIL t1_score got %0d want 5", score); else passes++;
        checks++; if (oxygen !== 7'd100) $display("FAIL t1_oxygen got %0d want 100", oxygen); else passes++;
        checks++; if (hit_pulse !== 1'b1) $display("FAIL t1_hit_pulse got %b want 1", hit_pulse); else passes++;
        step(1'b0, 7'd0, 7'd0);
        checks++; if (hit_pulse !== 1'b0) $display("FAIL t1_hit_pulse_drop got %b want 0", hit_pulse); else passes++;
    endtask

    task automatic test_cooldown();
        repeat (5) step(1'b1, 7'b0000100, 7'd0);
        checks++; if (score !== 10'd5) $display("FAIL t2_held_score got %0d want 5", score); else passes++;
        checks++; if (pop_req !== 7'b0000100) $display("FAIL t2_held_pop got %b want 0000100", pop_req); else passes++;
        step(1'b0, 7'd0, 7'b0000100);
        checks++; if (pop_req !== 7'd0) $display("FAIL t2_ack_pop got %b want 0", pop_req); else passes++;
        repeat (8) step(1'b1, 7'b0000100, 7'd0);
        checks++; if (score !== 10'd5) $display("FAIL t2_cool_score got %0d want 5", score); else passes++;
        step(1'b1, 7'b0000100, 7'd0);
        checks++; if (score !== 10'd10) $display("FAIL t2_frame9_score got %0d want 10", score); else passes++;
        checks++; if (pop_req !== 7'b0000100) $display("FAIL t2_frame9_pop got %b want 0000100", pop_req); else passes++;
    endtask

    task automatic test_all_hit();
        do_reset();
        repeat (1500) step(1'b1, 7'd0, 7'd0);
        checks++; if (oxygen !== 7'd50) $display("FAIL t3_preset_oxygen got %0d want 50", oxygen); else passes++;
        step(1'b1, 7'h7F, 7'd0);
        checks++; if (pop_req !== 7'h7F) $display("FAIL t3_pop got %b want 1111111", pop_req); else passes++;
        checks++; if (score !== 10'd35) $display("FAIL t3_score got %0d want 35", score); else passes++;
        checks++; if (oxygen !== 7'd100) $display("FAIL t3_oxygen got %0d want 100", oxygen); else passes++;
    endtask

    task automatic test_game_over();
        do_reset();
        repeat (2999) step(1'b1, 7'd0, 7'd0);
        checks++; if (oxygen !== 7'd1) $display("FAIL t4_oxygen_pre got %0d want 1", oxygen); else passes++;
        checks++; if (game_over !== 1'b0) $display("FAIL t4_go_pre got %b want 0", game_over); else passes++;
        step(1'b1, 7'd0, 7'd0);
        checks++; if (oxygen !== 7'd0) $display("FAIL t4_oxygen got %0d want 0", oxygen); else passes++;
        checks++; if (game_over !== 1'b1) $display("FAIL t4_go got %b want 1", game_over); else passes++;
        repeat (3) step(1'b1, 7'h7F, 7'd0);
        checks++; if (score !== 10'd0) $display("FAIL t4_frozen_score got %0d want 0", score); else passes++;
        checks++; if (pop_req !== 7'd0) $display("FAIL t4_frozen_pop got %b want 0", pop_req); else passes++;
        checks++; if (game_over !== 1'b1) $display("FAIL t4_sticky got %b want 1", game_over); else passes++;
    endtask

    task automatic test_hit_with_dec();
        do_reset();
        repeat (2429) step(1'b1, 7'd0, 7'd0);
        checks++; if (oxygen !== 7'd20) $display("FAIL t5_oxygen_pre got %0d want 20", oxygen); else passes++;
        step(1'b1, 7'b0000001, 7'd0);
        checks++; if (oxygen !== 7'd29) $display("FAIL t5_oxygen got %0d want 29", oxygen); else passes++;
        checks++; if (score !== 10'd5) $display("FAIL t5_score got %0d want 5", score); else passes++;
    endtask

    // One full round: all seven bubbles hit, acked, then cooled down.
    task automatic full_round();
        step(1'b1, 7'h7F, 7'd0);
        step(1'b0, 7'd0, 7'h7F);
        repeat (8) step(1'b1, 7'd0, 7'd0);
    endtask

    task automatic test_score_saturate();
        do_reset();
        repeat (30) full_round();
        checks++; if (score !== 10'd1023) $display("FAIL score_sat got %0d want 1023", score); else passes++;
    endtask

    task automatic test_async_reset_mid_handshake();
        do_reset();
        repeat (11) full_round();
        step(1'b1, 7'b0010011, 7'd0);
        step(1'b0, 7'd0, 7'b0000010);
        checks++; if (score !== 10'd400) $display("FAIL t6_score_pre got %0d want 400", score); else passes++;
        checks++; if (pop_req !== 7'b0010001) $display("FAIL t6_pop_pre got %b want 0010001", pop_req); else passes++;
        do_reset();
        step(1'b1, 7'b0010001, 7'd0);
        checks++; if (pop_req !== 7'b0010001) $display("FAIL t6_post_pop got %b want 0010001", pop_req); else passes++;
        checks++; if (score !== 10'd10) $display("FAIL t6_post_score got %0d want 10", score); else passes++;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout got no finish want finish within 5ms");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_hit();
        test_cooldown();
        test_all_hit();
        test_game_over();
        test_hit_with_dec();
        test_score_saturate();
        test_async_reset_mid_handshake();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bubble_hit_manager.md
Name: bubble_hit_manager

Overview:
Consumes the per-bubble collision flags from the swimmer/bubble collision stage. Once per frame it turns new swimmer-bubble contacts into pop requests to the bubble movers, with a request/acknowledge handshake. It also keeps the game score and the swimmer's oxygen level, and asserts game-over when oxygen reaches zero. It sits between collision detection and the bubble-control and HUD logic.

Parameters:
NUM_B, 7, number of bubbles (width of collision, request and ack vectors)
POINTS, 5, score added per popped bubble
O2_MAX, 100, oxygen reset value and saturation ceiling
O2_GAIN, 10, oxygen added per popped bubble
O2_PERIOD, 30, frames between 1-unit oxygen decrements
COOL_FRAMES, 8, frames a bubble ignores collisions after its respawn ack

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame; collision flags are stable on this cycle
collisionBS  in  NUM_B  registered collision flag per bubble
respawn_ack  in  NUM_B  per-bubble pulse from the bubble mover: bubble has been relocated
pop_req  out  NUM_B  per-bubble pop/respawn request, level, held until ack
score  out  10  running score, saturates at 1023
oxygen  out  7  current oxygen level
hit_pulse  out  1  one-cycle pulse on the cycle after any frame that produced at least one new hit
game_over  out  1  sticky; set when oxygen reaches 0

Behaviour:
- Reset (async, any time including mid-handshake) drives the following values:
  - pop_req=0, score=0, oxygen=O2_MAX, hit_pulse=0, game_over=0.
  - Every bubble FSM goes to ACTIVE; frame counter=0; cooldown counters=0.
- Per-bubble FSM; all transitions occur on clock edges.
  - ACTIVE: if frame_tick & collisionBS[i] & !game_over, go to POPPED and set pop_req[i]=1 on the next edge. That frame counts as a new hit for bubble i.
  - POPPED: pop_req[i] is held at 1 and collisions are ignored. On respawn_ack[i], clear pop_req[i] on the next edge, load cooldown[i]=COOL_FRAMES, and go to COOLDOWN.
  - COOLDOWN: decrement cooldown[i] on each frame_tick. When it reaches 0, go to ACTIVE. A collision on the same frame_tick that decrements to 0 is ignored; a hit requires a later frame_tick.
  - An ack arriving while a bubble is in ACTIVE or COOLDOWN is ignored.
- Scoring, evaluated on frame_tick cycles only. Let n = number of bubbles entering POPPED this frame (0..NUM_B).
  - score <= min(score + n*POINTS, 1023). The arithmetic is done at 13-bit width before clamping.
  - hit_pulse=1 for exactly the one cycle after a frame_tick with n>0.
- Oxygen, evaluated on frame_tick cycles only.
  - The frame counter counts 0..O2_PERIOD-1 and wraps. dec=1 on the tick where the counter wraps.
  - oxygen <= clamp(oxygen + n*O2_GAIN - dec, 0, O2_MAX), computed signed at 10 bits. A simultaneous hit and decrement nets out.
  - If the result is 0, game_over is set on the same edge.
- Once game_over=1:
  - score, oxygen and the frame counter freeze.
  - No new hits are taken.
  - Bubbles already in POPPED still complete their ack handshake, and cooldowns keep running.
  - Only reset clears game_over.
- Latency: collision sampled on frame_tick cycle T; pop_req, score and oxygen update at the edge ending T; hit_pulse is high during T+1.
- Every output is a register; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then a single collisionBS=7'b0000100 with frame_tick -> pop_req=7'b0000100 next cycle; score=5; oxygen=100 (clamped); hit_pulse high for 1 cycle.
2. Hold collisionBS[2] high for 5 frames with no ack -> score stays 5; pop_req[2] stays high. Then ack -> pop_req[2]=0; hits are ignored for 8 frames; a hit on frame 9 gives score=10.
3. collisionBS=7'b1111111 on one frame -> pop_req=7'h7F; score +35. With oxygen preset at 50, oxygen=100 (saturated).
4. No hits for 30*100 frames -> oxygen steps down by 1 every 30 frames; game_over=1 exactly when oxygen hits 0. Later collisions change neither score nor pop_req.
5. A hit on the same frame_tick as a decrement, with oxygen=20 -> oxygen=29.
6. Assert reset asynchronously mid-frame, with pop_req=7'b0010001 and score=400 -> all outputs return to reset values immediately, without waiting for a clock edge.
